nway_switch_lamp: RTL and testbench

- Parametrised N-way lamp controller for the board I/O layer.
- Any of NSW switches toggles one lamp, which generalises the classic two-way/three-way stair switch.
- Adds per-switch synchronisation and debounce, a master-off button and an optional auto-off timer.
- Sits between the raw board inputs (sw, btn) and an LED output in top-level board designs.

---
 rtl/nway_switch_lamp.sv | 55 +++++
 tb/tb_nway_switch_lamp.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/nway_switch_lamp.sv
// nway_switch_lamp: N-way stair-switch lamp controller with debounced inputs, a master-off button and an auto-off timer
module nway_switch_lamp #(
  parameter int NSW = 4,
  parameter int DEB_CYCLES = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NSW-1:0] sw,
  input  logic           off_btn,
  output logic           lamp,
  output logic [NSW-1:0] sw_db,
  output logic           toggle_pulse
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] DMAX = CW'(DEB_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [NSW:0] s1, s2, db;
  logic [CW-1:0] cnt [NSW+1];
  logic btn_db_d, offset, pre, off_edge, timeout_hit, lamp_nxt;
  logic [TW-1:0] timer;
  assign sw_db = db[NSW-1:0];
  assign off_edge = db[NSW] & ~btn_db_d;
  assign pre = ^sw_db ^ offset;
  assign timeout_hit = (TIMEOUT != 0) && lamp && timer == TMAX;
  // a forced off only matters while the parity would light the lamp; flipping offset re-arms every switch
  assign lamp_nxt = pre & ~(off_edge | timeout_hit);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      for (int k = 0; k <= NSW; k++) cnt[k] <= '0;
      btn_db_d <= 1'b0;
      offset <= 1'b0;
      timer <= '0;
      lamp <= 1'b0;
      toggle_pulse <= 1'b0;
    end else begin
      s1 <= {off_btn, sw};
      s2 <= s1;
      for (int k = 0; k <= NSW; k++)
        if (s2[k] == db[k]) cnt[k] <= '0;
        else if (cnt[k] == DMAX) begin
          db[k] <= s2[k];
          cnt[k] <= '0;
        end else cnt[k] <= cnt[k] + 1'b1;
      btn_db_d <= db[NSW];
      offset <= offset ^ (pre & (off_edge | timeout_hit));
      lamp <= lamp_nxt;
      toggle_pulse <= lamp_nxt ^ lamp;
      timer <= (TIMEOUT == 0 || !lamp || lamp_nxt != lamp) ? '0 : timer == TMAX ? timer : timer + 1'b1;
    end
endmodule

// File: tb/tb_nway_switch_lamp.sv
// tb_nway_switch_lamp: directed table, corner sequences and randomized model checks for nway_switch_lamp
module tb_nway_switch_lamp;
  localparam int NSW = 4, DEB = 4;
  logic clk = 0, rst = 1, off_btn = 0;
  logic [NSW-1:0] sw = '0, sw_db, sw_db0;
  logic lamp, lamp0, tp, tp0;
  int checks = 0, failures = 0, p = 0, p0 = 0;

  typedef struct {
    logic [3:0] sw;
    logic       btn;
    int         hold;
    logic       lamp;
    logic [3:0] db;
    int         pulses;
  } vec_t;
  vec_t tbl [13];

  always #5 clk = ~clk;

  nway_switch_lamp #(.NSW(NSW), .DEB_CYCLES(DEB), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst), .sw(sw), .off_btn(off_btn),
    .lamp(lamp), .sw_db(sw_db), .toggle_pulse(tp));
  nway_switch_lamp #(.NSW(NSW), .DEB_CYCLES(DEB), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst), .sw(sw), .off_btn(off_btn),
    .lamp(lamp0), .sw_db(sw_db0), .toggle_pulse(tp0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (tp) p++;
      if (tp0) p0++;
    end
  endtask

  initial begin
    int n, bad, k, j, h, expp;
    logic lamp_m;
    logic [3:0] sw_m;
    tbl[0]  = '{4'b1100, 1'b0, 12, 1'b0, 4'b1100, 0};
    tbl[1]  = '{4'b1110, 1'b0, 12, 1'b1, 4'b1110, 1};
    tbl[2]  = '{4'b1110, 1'b1, 20, 1'b0, 4'b1110, 1};
    tbl[3]  = '{4'b1110, 1'b0, 14, 1'b0, 4'b1110, 0};
    tbl[4]  = '{4'b1100, 1'b0, 12, 1'b1, 4'b1100, 1};
    tbl[5]  = '{4'b1100, 1'b1, 20, 1'b0, 4'b1100, 1};
    tbl[6]  = '{4'b1100, 1'b0, 14, 1'b0, 4'b1100, 0};
    tbl[7]  = '{4'b1100, 1'b1, 20, 1'b0, 4'b1100, 0};
    tbl[8]  = '{4'b1100, 1'b0, 14, 1'b0, 4'b1100, 0};
    tbl[9]  = '{4'b1000, 1'b1, 20, 1'b0, 4'b1000, 0};
    tbl[10] = '{4'b1000, 1'b0, 14, 1'b0, 4'b1000, 0};
    tbl[11] = '{4'b1001, 1'b0, 12, 1'b1, 4'b1001, 1};
    tbl[12] = '{4'b1011, 1'b0, 12, 1'b0, 4'b1011, 1};

    step(3);
    rst = 0;
    check("reset_lamp", lamp, 0);
    check("reset_sw_db", sw_db, 0);
    check("reset_pulse", tp, 0);

    sw = 4'b0001;
    step(1);
    step(5);
    check("lat_db_edge5", sw_db[0], 0);
    step(1);
    check("lat_db_edge6", sw_db[0], 1);
    check("lat_lamp_edge6", lamp, 0);
    step(1);
    check("lat_lamp_edge7", lamp, 1);
    check("lat_pulse_edge7", tp, 1);
    step(1);
    check("lat_pulse_edge8", tp, 0);
    sw = 4'b0101;
    step(7);
    check("off_lamp_edge6", lamp, 1);
    step(1);
    check("off_lamp_edge7", lamp, 0);

    p = 0;
    sw = 4'b0111;
    step(3);
    sw = 4'b0101;
    step(12);
    check("glitch_db", sw_db, 4'b0101);
    check("glitch_lamp", lamp, 0);
    check("glitch_pulses", p, 0);

    for (int i = 0; i < 13; i++) begin
      sw = tbl[i].sw;
      off_btn = tbl[i].btn;
      p = 0;
      step(tbl[i].hold);
      check($sformatf("row%0d_lamp", i), lamp, tbl[i].lamp);
      check($sformatf("row%0d_db", i), sw_db, tbl[i].db);
      check($sformatf("row%0d_pulses", i), p, tbl[i].pulses);
    end

    sw = 4'b1111;
    n = 0;
    while (!lamp && n < 20) begin
      step(1);
      n++;
    end
    check("timeout_on", lamp, 1);
    n = 0;
    while (lamp && n < 200) begin
      step(1);
      n++;
    end
    check("timeout_cycles", n, 50);
    bad = 0;
    repeat (10000) begin
      step(1);
      if (lamp0 !== 1'b1) bad++;
    end
    check("no_timeout_hold", bad, 0);
    check("timeout_stays_off", lamp, 0);
    sw = 4'b1110;
    step(12);
    check("after_timeout_sw", lamp, 1);
    check("no_timeout_sw", lamp0, 0);

    #2;
    rst = 1;
    #1;
    check("async_rst_lamp", lamp, 0);
    check("async_rst_db", sw_db, 0);
    sw = '0;
    step(2);
    rst = 0;
    step(12);
    check("post_rst_lamp", lamp, 0);
    check("post_rst_lamp0", lamp0, 0);

    lamp_m = 0;
    sw_m = '0;
    for (int r = 0; r < 40; r++) begin
      p0 = 0;
      k = $urandom_range(0, NSW - 1);
      h = $urandom_range(6, 20);
      case ($urandom_range(0, 4))
        0: begin
          sw_m = sw_m ^ (4'b1 << k);
          sw = sw_m;
          lamp_m = ~lamp_m;
          expp = 1;
          step(12);
        end
        1: begin
          j = (k + $urandom_range(1, NSW - 1)) % NSW;
          sw_m = sw_m ^ (4'b1 << k) ^ (4'b1 << j);
          sw = sw_m;
          expp = 0;
          step(12);
        end
        2: begin
          sw = sw_m ^ (4'b1 << k);
          step($urandom_range(1, DEB - 1));
          sw = sw_m;
          expp = 0;
          step(12);
        end
        3: begin
          off_btn = 1;
          step(h);
          off_btn = 0;
          step(14);
          expp = lamp_m ? 1 : 0;
          lamp_m = 0;
        end
        default: begin
          sw_m = sw_m ^ (4'b1 << k);
          sw = sw_m;
          off_btn = 1;
          step(h);
          off_btn = 0;
          step(14);
          expp = lamp_m ? 1 : 0;
          lamp_m = 0;
        end
      endcase
      check($sformatf("rand%0d_lamp", r), lamp0, lamp_m);
      check($sformatf("rand%0d_db", r), sw_db0, sw_m);
      check($sformatf("rand%0d_pulses", r), p0, expp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
